// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and small-sigma functions, used by the schedule and compression stages.
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam int SHA256_ROUNDS = 64;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } sched_state_e;

  function automatic word_t s0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic word_t s1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Block-load and word-stream handshake between the round controller and the message schedule.
interface sha256_msg_schedule_if;
  import sha256_pkg::*;

  logic         load_valid;
  logic         load_ready;
  logic [511:0] block_in;
  logic         advance;
  logic         abort;
  word_t        w_out;
  logic         w_valid;
  logic [6:0]   round;
  logic         done;

  modport master (
    output load_valid, block_in, advance, abort,
    input  load_ready, w_out, w_valid, round, done
  );

  modport slave (
    input  load_valid, block_in, advance, abort,
    output load_ready, w_out, w_valid, round, done
  );
endinterface

// File: rtl/sha256_msg_schedule_round_counter.sv
// Round index for the message schedule: synchronous clear wins over enable.
module msg_round_counter #(
  parameter int ROUNDS = 64
) (
  input  logic       clk,
  input  logic       clear_i,
  input  logic       en_i,
  output logic [6:0] count_o,
  output logic       terminal_o
);

  logic [6:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)   cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 7'd1;
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign count_o    = cnt_q;
  assign terminal_o = (cnt_q == 7'(ROUNDS - 1));

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 512-bit block and streams W[0..ROUNDS-1], one word per advance.
//   state  | meaning
//   S_IDLE | waiting for a block, load_ready=1, outputs zero
//   S_RUN  | w_out=W[round] from window[0], steps on advance
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int ROUNDS = SHA256_ROUNDS
) (
  input logic                 clk,
  input logic                 rst,
  sha256_msg_schedule_if.slave bus
);

  sched_state_e state_q;
  word_t        win_q [16];
  word_t        w_new;
  logic         w_valid_q, done_q, load_ready_q;
  logic [6:0]   round;
  logic         last, step, cnt_clear;

  assign step      = (state_q == S_RUN) && bus.advance && !bus.abort;
  assign cnt_clear = rst || bus.abort || (state_q != S_RUN) || (step && last);

  msg_round_counter #(.ROUNDS(ROUNDS)) u_round_cnt (
    .clk        (clk),
    .clear_i    (cnt_clear),
    .en_i       (step),
    .count_o    (round),
    .terminal_o (last)
  );

  assign w_new = s1(win_q[14]) + win_q[9] + s0(win_q[1]) + win_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      w_valid_q    <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b1;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else if (bus.abort) begin
      // Window contents are left stale; they are hidden until the next load overwrites them.
      state_q      <= S_IDLE;
      w_valid_q    <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.load_valid && load_ready_q) begin
            for (int i = 0; i < 16; i++) win_q[i] <= bus.block_in[511-32*i -: 32];
            state_q      <= S_RUN;
            w_valid_q    <= 1'b1;
            load_ready_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (bus.advance) begin
            if (last) begin
              state_q      <= S_IDLE;
              w_valid_q    <= 1'b0;
              done_q       <= 1'b1;
              load_ready_q <= 1'b1;
            end else begin
              for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
              win_q[15] <= w_new;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.w_valid    = w_valid_q;
  assign bus.done       = done_q;
  assign bus.round      = round;
  assign bus.w_out      = w_valid_q ? win_q[0] : '0;

endmodule
